axi_rd_slave_mem: RTL and testbench
===================================

Name: axi_rd_slave_mem

Overview:
AXI4 read-channel slave with an internal word memory. It is the downstream consumer of the AXI master's AR channel and the producer of its R channel. It decodes FIXED, INCR and WRAP bursts and returns one beat per R handshake. A sideband preload port lets the bench or a write-side block fill the memory.

Parameters:
ID_WIDTH, 4, AR/R ID width
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width (power of 2, >= 8)
LEN_WIDTH, 8, ARLEN width
SIZE_WIDTH, 3, ARSIZE width
BURST_WIDTH, 2, ARBURST width
MEM_DEPTH, 256, memory depth in DATA_WIDTH words

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  start byte address
arlen  in  LEN_WIDTH  beats minus 1
arsize  in  SIZE_WIDTH  log2 bytes per beat
arburst  in  BURST_WIDTH  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  ID echoed from AR
rdata  out  DATA_WIDTH  full memory word
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
mem_we  in  1  preload write enable
mem_waddr  in  clog2(MEM_DEPTH)  preload word index
mem_wdata  in  DATA_WIDTH  preload data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low. Assertion clears all state immediately.
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, state=IDLE. Memory contents are not reset.
- arready goes to 1 on the first posedge after rst_n deasserts, and stays 1 in IDLE.
- FSM, IDLE:
  - arready=1.
  - On arvalid&&arready, register id, addr, len, size and burst, clear beat_cnt, and go to BURST.
  - arready=0 from the next cycle.
- FSM, BURST:
  - rvalid=1 from the first cycle after the AR handshake (1-cycle AR-to-R latency).
  - Each rvalid&&rready advances the beat address and beat_cnt.
  - rlast=1 when beat_cnt==len.
  - Handshake on the rlast beat returns to IDLE. rvalid=0 and arready=1 next cycle.
  - Minimum 1 idle cycle between bursts.
  - Only one burst is outstanding.
- Stall: while rvalid&&!rready, rid, rdata, rresp and rlast hold stable.
  - Exception: a preload write to the current word updates rdata the next cycle. Benches must not do this.
- Address arithmetic:
  - LSB = log2(DATA_WIDTH/8); word index = addr>>LSB.
  - rdata is the full word; no lane shifting for narrow sizes.
  - incr = 1<<size.
  - FIXED: address unchanged.
  - INCR: addr += incr, ADDR_WIDTH wrap-around, no 4KB check.
  - WRAP: bound = (len+1)<<size; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- Error rules:
  - Burst-level SLVERR applies to all beats of the burst with rdata=0, when any of these hold:
    - size > LSB;
    - burst==3;
    - WRAP with len not in {1,3,7,15}.
  - Per-beat SLVERR with rdata=0 when word index >= MEM_DEPTH. Other beats of the same burst stay OKAY.
  - The full beat count is always returned.
- Preload: mem_we writes mem[mem_waddr] at posedge, at any time including mid-burst. The new value is visible to a read beat from the next cycle.
- Reset mid-burst: outputs drop to their reset values immediately. The burst is discarded and no further beats are sent.

Test Plan:
- Preload mem[4..7]=0xA0..0xA3; AR id=3, addr=0x10, len=3, size=2, INCR, rready=1 -> rvalid 1 cycle after AR handshake; rdata A0,A1,A2,A3 on consecutive cycles; rid=3; rresp=0; rlast only on beat 4; arready=1 the cycle after the last beat.
- Same burst with rready low for 3 cycles at beat 2 -> rdata=A1, rlast=0 held stable for all 3 stall cycles; total 4 beats.
- WRAP addr=0x38, len=3, size=2 -> beat addresses 0x38,0x3C,0x30,0x34; rlast on beat 4.
- FIXED addr=0x08, len=2 -> mem[2] returned 3 times.
- INCR addr=0x3F8, len=3, MEM_DEPTH=256 -> beats 1-2 OKAY from mem[254..255]; beats 3-4 rresp=2'b10, rdata=0.
- size=3 on 32-bit bus, len=1 -> 2 beats, both SLVERR.
- WRAP with len=2 -> 3 beats, all SLVERR.
- rst_n pulsed low during beat 2 -> rvalid=0 and arready=0 immediately; arready=1 one cycle after release; a new AR is then accepted normally.

Source files
------------

// File: rtl/axi_rd_slave_mem.sv
// AXI4 read-channel slave backed by a word memory with a sideband preload port.
// Decodes FIXED/INCR/WRAP bursts, one outstanding burst, one beat per R handshake.
module axi_rd_slave_mem #(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned BURST_WIDTH = 2,
    parameter int unsigned MEM_DEPTH   = 256,
    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ID_WIDTH-1:0]    arid,
    input  logic [ADDR_WIDTH-1:0]  araddr,
    input  logic [LEN_WIDTH-1:0]   arlen,
    input  logic [SIZE_WIDTH-1:0]  arsize,
    input  logic [BURST_WIDTH-1:0] arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [ID_WIDTH-1:0]    rid,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic                   mem_we,
    input  logic [IDX_W-1:0]       mem_waddr,
    input  logic [DATA_WIDTH-1:0]  mem_wdata
);

    localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic [BURST_WIDTH-1:0]  burst_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_q;
    logic                    berr_q;

    logic                    arready_q;
    logic [ID_WIDTH-1:0]     rid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;
    logic                    rvalid_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    r_hs_c;
    logic [ADDR_WIDTH-1:0]   incr_c;
    logic [ADDR_WIDTH-1:0]   wmask_c;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH-1:0]   ld_addr_c;
    logic [ADDR_WIDTH-1:0]   ld_word_c;
    logic                    ld_berr_c;
    logic [DATA_WIDTH-1:0]   ld_data_c;
    logic [1:0]              ld_resp_c;

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;

    // Burst-wide error: oversized beat, reserved burst type, or illegal WRAP length.
    function automatic logic burst_err(input logic [SIZE_WIDTH-1:0]  s,
                                       input logic [BURST_WIDTH-1:0] b,
                                       input logic [LEN_WIDTH-1:0]   l);
        logic wrap_ok;
        wrap_ok = (l == LEN_WIDTH'(1)) || (l == LEN_WIDTH'(3)) ||
                  (l == LEN_WIDTH'(7)) || (l == LEN_WIDTH'(15));
        return (32'(s) > LSB) || (b == BURST_WIDTH'(3)) ||
               ((b == BURST_WIDTH'(2)) && !wrap_ok);
    endfunction

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next beat address and the data/response for whichever beat is loaded this cycle.
    always_comb begin
        r_hs_c  = rvalid_q && rready;
        incr_c  = ADDR_WIDTH'(1) << size_q;
        wmask_c = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        addr_d  = addr_q + incr_c;
        if (burst_q == BURST_WIDTH'(0)) begin
            addr_d = addr_q;
        end else if (burst_q == BURST_WIDTH'(2)) begin
            addr_d = (addr_q & ~wmask_c) | ((addr_q + incr_c) & wmask_c);
        end

        ld_addr_c = addr_q;
        ld_berr_c = berr_q;
        if (state_q == IDLE) begin
            ld_addr_c = araddr;
            ld_berr_c = burst_err(arsize, arburst, arlen);
        end else if (r_hs_c) begin
            ld_addr_c = addr_d;
        end

        ld_word_c = ld_addr_c >> LSB;
        ld_data_c = '0;
        ld_resp_c = RESP_SLVERR;
        if (!ld_berr_c && (ld_word_c < ADDR_WIDTH'(MEM_DEPTH))) begin
            ld_data_c = mem[IDX_W'(ld_word_c)];
            ld_resp_c = RESP_OKAY;
        end
    end

    // Burst FSM with registered AR/R outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            berr_q     <= 1'b0;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        addr_q     <= araddr;
                        len_q      <= arlen;
                        size_q     <= arsize;
                        burst_q    <= arburst;
                        beat_cnt_q <= '0;
                        berr_q     <= ld_berr_c;
                        rid_q      <= arid;
                        rdata_q    <= ld_data_c;
                        rresp_q    <= ld_resp_c;
                        rlast_q    <= (arlen == '0);
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (r_hs_c && rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        // Reload every cycle so a stalled beat tracks preload writes.
                        rdata_q <= ld_data_c;
                        rresp_q <= ld_resp_c;
                        if (r_hs_c) begin
                            addr_q     <= addr_d;
                            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                            rlast_q    <= ((beat_cnt_q + LEN_WIDTH'(1)) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Directed bench for axi_rd_slave_mem: burst types, stalls, error responses, mid-burst reset.
module tb_axi_rd_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    axi_rd_slave_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = val;
        step();
        mem_we    = 1'b0;
    endtask

    // Issue one AR and consume len+1 beats, optionally stalling rready at one beat.
    task automatic do_burst(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int stall_at, input int stall_n);
        chk({name, " arready_before"}, 64'(arready), 64'(1));
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        rready  = 1'b1;
        step();
        arvalid = 1'b0;
        chk({name, " arready_busy"}, 64'(arready), 64'(0));
        for (int b = 0; b <= int'(len); b++) begin
            chk($sformatf("%s b%0d rvalid", name, b), 64'(rvalid), 64'(1));
            chk($sformatf("%s b%0d rdata", name, b), 64'(rdata), 64'(exp_data[b]));
            chk($sformatf("%s b%0d rresp", name, b), 64'(rresp), 64'(exp_resp[b]));
            chk($sformatf("%s b%0d rlast", name, b), 64'(rlast), 64'(b == int'(len)));
            chk($sformatf("%s b%0d rid", name, b), 64'(rid), 64'(id));
            if (b == stall_at) begin
                rready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk($sformatf("%s stall%0d rvalid", name, s), 64'(rvalid), 64'(1));
                    chk($sformatf("%s stall%0d rdata", name, s), 64'(rdata), 64'(exp_data[b]));
                    chk($sformatf("%s stall%0d rlast", name, s), 64'(rlast), 64'(b == int'(len)));
                end
                rready = 1'b1;
            end
            step();
        end
        chk({name, " rvalid_after"}, 64'(rvalid), 64'(0));
        chk({name, " arready_after"}, 64'(arready), 64'(1));
        step();
    endtask

    task automatic set_exp(input int b, input logic [31:0] d, input logic [1:0] r);
        exp_data[b] = d;
        exp_resp[b] = r;
    endtask

    initial begin
        rst_n     = 1'b0;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        #1;
        chk("rst arready", 64'(arready), 64'(0));
        chk("rst rvalid", 64'(rvalid), 64'(0));
        chk("rst rlast", 64'(rlast), 64'(0));
        chk("rst rresp", 64'(rresp), 64'(0));
        chk("rst rid", 64'(rid), 64'(0));
        chk("rst rdata", 64'(rdata), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel arready_0", 64'(arready), 64'(0));
        step();
        chk("rel arready_1", 64'(arready), 64'(1));

        for (int i = 0; i < 4; i++) preload(8'(4 + i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) preload(8'(12 + i), 32'hC0 + 32'(i));
        preload(8'd2, 32'h22);
        preload(8'd254, 32'hFE);
        preload(8'd255, 32'hFF);

        // INCR, no stall
        for (int i = 0; i < 4; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
        do_burst("incr", 4'd3, 32'h10, 8'd3, 3'd2, 2'd1, -1, 0);

        // INCR with 3-cycle stall at beat 2
        do_burst("stall", 4'd3, 32'h10, 8'd3, 3'd2, 2'd1, 1, 3);

        // WRAP: 0x38,0x3C,0x30,0x34 -> words 14,15,12,13
        set_exp(0, 32'hC2, 2'b00);
        set_exp(1, 32'hC3, 2'b00);
        set_exp(2, 32'hC0, 2'b00);
        set_exp(3, 32'hC1, 2'b00);
        do_burst("wrap", 4'd5, 32'h38, 8'd3, 3'd2, 2'd2, -1, 0);

        // FIXED: mem[2] three times
        for (int i = 0; i < 3; i++) set_exp(i, 32'h22, 2'b00);
        do_burst("fixed", 4'd1, 32'h08, 8'd2, 3'd2, 2'd0, -1, 0);

        // INCR running off the end of memory
        set_exp(0, 32'hFE, 2'b00);
        set_exp(1, 32'hFF, 2'b00);
        set_exp(2, 32'h0, 2'b10);
        set_exp(3, 32'h0, 2'b10);
        do_burst("oob", 4'd7, 32'h3F8, 8'd3, 3'd2, 2'd1, -1, 0);

        // Oversized beat on 32-bit bus
        set_exp(0, 32'h0, 2'b10);
        set_exp(1, 32'h0, 2'b10);
        do_burst("size3", 4'd2, 32'h10, 8'd1, 3'd3, 2'd1, -1, 0);

        // Illegal WRAP length
        for (int i = 0; i < 3; i++) set_exp(i, 32'h0, 2'b10);
        do_burst("wraplen", 4'd9, 32'h10, 8'd2, 3'd2, 2'd2, -1, 0);

        // Reserved burst type
        set_exp(0, 32'h0, 2'b10);
        do_burst("rsvd", 4'd4, 32'h10, 8'd0, 3'd2, 2'd3, -1, 0);

        // Reset during beat 2
        arid    = 4'd6;
        araddr  = 32'h10;
        arlen   = 8'd3;
        arsize  = 3'd2;
        arburst = 2'd1;
        arvalid = 1'b1;
        rready  = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        chk("mrst beat2 rdata", 64'(rdata), 64'hA1);
        rst_n = 1'b0;
        #1;
        chk("mrst rvalid", 64'(rvalid), 64'(0));
        chk("mrst arready", 64'(arready), 64'(0));
        chk("mrst rlast", 64'(rlast), 64'(0));
        step();
        rst_n = 1'b1;
        #1;
        chk("mrst rel rvalid", 64'(rvalid), 64'(0));
        chk("mrst rel arready_0", 64'(arready), 64'(0));
        step();
        chk("mrst rel arready_1", 64'(arready), 64'(1));
        chk("mrst no_beats", 64'(rvalid), 64'(0));

        for (int i = 0; i < 4; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
        do_burst("post_rst", 4'd8, 32'h10, 8'd3, 3'd2, 2'd1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
